// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the IF/LSB memory arbiter
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    LS_RD  = 3'd2,
    LS_FIN = 3'd3,
    LS_WR  = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Offset of the final byte of an LSB access; the reserved encoding behaves as a word.
  function automatic logic [1:0] last_offset(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - RAM bus, IF fetch and LSB request signals of the memory arbiter
interface mem_ctrl_if;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;

  logic        lsb_req;
  logic        lsb_we;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  modport master (
    output mem_din, io_buffer_full,
    output if_req, if_addr,
    output lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  if_grant,
    input  lsb_done, lsb_rdata
  );

  modport slave (
    input  mem_din, io_buffer_full,
    input  if_req, if_addr,
    input  lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
    output mem_dout, mem_a, mem_wr,
    output if_grant,
    output lsb_done, lsb_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide single-port RAM arbiter between instruction fetch and load/store buffer
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input logic       clk_in,
  input logic       rst_in,
  input logic       rdy_in,
  input logic       control_hazard,
  mem_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cap_valid_q, cap_valid_d;
  logic [1:0]  cap_idx_q, cap_idx_d;
  logic [31:0] buf_q, buf_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ls_addr;
  logic [1:0]  last_k;
  logic        io_stall;
  logic        lsb_go;
  state_e      lsb_state;
  logic [31:0] merged;

  assign ls_addr   = bus.lsb_addr + {30'd0, k_q};
  assign last_k    = last_offset(bus.lsb_size);
  assign io_stall  = (ls_addr >= IO_BASE) && bus.io_buffer_full;
  assign lsb_go    = bus.lsb_req && !done_q;
  assign lsb_state = bus.lsb_we ? LS_WR : LS_RD;

  // The byte issued last active cycle lands on mem_din now, whether or not rdy_in is high.
  always_comb begin
    merged = buf_q;
    if (cap_valid_q) begin
      merged[{cap_idx_q, 3'b000} +: 8] = bus.mem_din;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      cnt_q       <= 2'd0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= 2'd0;
      buf_q       <= 32'd0;
      done_q      <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      buf_q       <= buf_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    cap_valid_d = 1'b0;
    cap_idx_d   = cap_idx_q;
    buf_d       = merged;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (lsb_go) begin
            state_d = lsb_state;
            k_d     = 2'd0;
            buf_d   = 32'd0;
          end else if (bus.if_req) begin
            state_d = IF_RD;
          end
        end
        IF_RD: begin
          if (control_hazard || !bus.if_req) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
            // Word boundary: hand the bus to the LSB without an idle cycle.
            if (cnt_q == 2'd3 && lsb_go) begin
              state_d = lsb_state;
              k_d     = 2'd0;
              buf_d   = 32'd0;
            end
          end
        end
        LS_RD: begin
          if (control_hazard) begin
            state_d = IDLE;
            k_d     = 2'd0;
            cnt_d   = 2'd0;
          end else begin
            cap_valid_d = 1'b1;
            cap_idx_d   = k_q;
            if (k_q == last_k) begin
              state_d = LS_FIN;
              k_d     = 2'd0;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        LS_FIN: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          if (!control_hazard) begin
            done_d  = 1'b1;
            rdata_d = merged;
          end
        end
        LS_WR: begin
          if (!io_stall) begin
            if (k_q == last_k) begin
              state_d = IDLE;
              k_d     = 2'd0;
              done_d  = 1'b1;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_a    = 32'd0;
    bus.mem_dout = 8'd0;
    bus.mem_wr   = 1'b0;
    bus.if_grant = 1'b0;
    if (!rst_in) begin
      unique case (state_q)
        IF_RD: begin
          if (bus.if_req) begin
            bus.mem_a    = bus.if_addr;
            bus.if_grant = rdy_in && !control_hazard;
          end
        end
        LS_RD: begin
          bus.mem_a = ls_addr;
        end
        LS_WR: begin
          bus.mem_a    = ls_addr;
          bus.mem_dout = bus.lsb_wdata[{k_q, 3'b000} +: 8];
          bus.mem_wr   = rdy_in && !io_stall;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.lsb_done  = done_q;
  assign bus.lsb_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed table-driven bench for mem_ctrl
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic control_hazard;

  mem_ctrl_if bus ();

  mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .control_hazard (control_hazard),
    .bus            (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [0:1023];
  logic [7:0] rd_q = 8'd0;
  logic       ram_init = 1'b0;
  int         io_wr_cnt = 0;
  logic [7:0] io_last = 8'd0;

  always @(posedge clk_in) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'd0;
      ram[10'h100] <= 8'h78; ram[10'h101] <= 8'h56; ram[10'h102] <= 8'h34; ram[10'h103] <= 8'h12;
      ram[10'h104] <= 8'hEF; ram[10'h105] <= 8'hCD; ram[10'h106] <= 8'hAB; ram[10'h107] <= 8'h90;
      ram[10'h3FF] <= 8'hA5; ram[10'h000] <= 8'h5A;
      ram_init <= 1'b1;
    end else if (bus.mem_wr) begin
      if (bus.mem_a >= 32'h0003_0000) begin
        io_wr_cnt <= io_wr_cnt + 1;
        io_last   <= bus.mem_dout;
      end else begin
        ram[bus.mem_a[9:0]] <= bus.mem_dout;
      end
    end
    rd_q <= ram[bus.mem_a[9:0]];
  end

  assign bus.mem_din = rd_q;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called at posedge+1 of an idle cycle; returns cycles from acceptance to lsb_done (0 on timeout).
  task automatic do_lsb(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_lo, input int rdy_hi,
                        output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = 32'd0;
    bus.lsb_we    = we;
    bus.lsb_size  = size;
    bus.lsb_addr  = addr;
    bus.lsb_wdata = wdata;
    bus.lsb_req   = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_in);
      #1;
      rdy_in = !(c >= rdy_lo && c <= rdy_hi);
      #1;
      if (bus.lsb_done) begin
        lat = c;
        rd  = bus.lsb_rdata;
        break;
      end
    end
    bus.lsb_req = 1'b0;
    rdy_in      = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        gprev;
    logic [31:0] aprev;
    logic        exp_g;

    vecs[0]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h1234_5678, 6};
    vecs[1]  = '{1'b0, 2'd0, 32'h0000_0101, 32'h0,         32'h0000_0056, 3};
    vecs[2]  = '{1'b0, 2'd1, 32'h0000_0102, 32'h0,         32'h0000_1234, 4};
    vecs[3]  = '{1'b0, 2'd3, 32'h0000_0104, 32'h0,         32'h90AB_CDEF, 6};
    vecs[4]  = '{1'b1, 2'd1, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0,         3};
    vecs[5]  = '{1'b0, 2'd1, 32'h0000_0108, 32'h0,         32'h0000_BEEF, 4};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_010C, 32'hCAFE_F00D, 32'h0,         5};
    vecs[7]  = '{1'b0, 2'd2, 32'h0000_010C, 32'h0,         32'hCAFE_F00D, 6};
    vecs[8]  = '{1'b0, 2'd0, 32'h0000_010F, 32'h0,         32'h0000_00CA, 3};
    vecs[9]  = '{1'b1, 2'd0, 32'h0000_0110, 32'h0000_0077, 32'h0,         2};
    vecs[10] = '{1'b0, 2'd2, 32'h0000_0110, 32'h0,         32'h0000_0077, 6};
    vecs[11] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_5AA5, 4};

    rst_in = 1'b1; rdy_in = 1'b1; control_hazard = 1'b0;
    bus.io_buffer_full = 1'b0; bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.lsb_req = 1'b0; bus.lsb_we = 1'b0; bus.lsb_size = 2'd0;
    bus.lsb_addr = 32'd0; bus.lsb_wdata = 32'd0;

    repeat (2) @(posedge clk_in);
    #2;
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("reset mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("reset if_grant", {31'd0, bus.if_grant}, 32'd0);
    chk("reset lsb_done", {31'd0, bus.lsb_done}, 32'd0);
    chk("reset lsb_rdata", bus.lsb_rdata, 32'd0);

    // IF streaming from reset, with a byte load raised mid-word at t=6.
    rst_in = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'd0;
    gprev = 1'b0; aprev = 32'd0;
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk_in);
      #1;
      if (gprev) bus.if_addr = bus.if_addr + 32'd1;
      if (t == 6) begin
        bus.lsb_we = 1'b0; bus.lsb_size = 2'd0; bus.lsb_addr = 32'h101; bus.lsb_req = 1'b1;
      end
      if (t == 12) bus.lsb_req = 1'b0;
      #1;
      exp_g = (t <= 8) || (t >= 12);
      chk($sformatf("stream grant t=%0d", t), {31'd0, bus.if_grant}, {31'd0, exp_g});
      if (exp_g) chk($sformatf("stream mem_a t=%0d", t), bus.mem_a, bus.if_addr);
      if (t == 9) chk("boundary ls addr", bus.mem_a, 32'h101);
      chk($sformatf("stream mem_wr t=%0d", t), {31'd0, bus.mem_wr}, 32'd0);
      chk($sformatf("stream done t=%0d", t), {31'd0, bus.lsb_done}, {31'd0, (t == 11)});
      if (t == 11) chk("boundary load data", bus.lsb_rdata, 32'h0000_0056);
      if (gprev) chk($sformatf("stream mem_din t=%0d", t), {24'd0, bus.mem_din}, {24'd0, ram[aprev[9:0]]});
      gprev = bus.if_grant;
      aprev = bus.mem_a;
    end
    bus.if_req = 1'b0;
    next_cycle();
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      do_lsb(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, 0, -1, lat, rd);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      next_cycle();
    end

    // rdy_in low for two cycles mid-load: the in-flight byte is still captured.
    do_lsb(1'b0, 2'd2, 32'h104, 32'd0, 2, 3, lat, rd);
    chk("rdy stall latency", lat, 8);
    chk("rdy stall rdata", rd, 32'h90AB_CDEF);
    next_cycle();

    // IO store stalled by io_buffer_full for three cycles.
    bus.io_buffer_full = 1'b1;
    bus.lsb_we = 1'b1; bus.lsb_size = 2'd0; bus.lsb_addr = 32'h0003_0000;
    bus.lsb_wdata = 32'h0000_0041; bus.lsb_req = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk_in);
      #1;
      if (j == 4) bus.io_buffer_full = 1'b0;
      #1;
      if (j <= 3) begin
        chk($sformatf("io stall mem_wr j=%0d", j), {31'd0, bus.mem_wr}, 32'd0);
        chk($sformatf("io stall mem_a j=%0d", j), bus.mem_a, 32'h0003_0000);
      end
      if (j == 4) begin
        chk("io write mem_wr", {31'd0, bus.mem_wr}, 32'd1);
        chk("io write mem_dout", {24'd0, bus.mem_dout}, 32'h41);
      end
      chk($sformatf("io done j=%0d", j), {31'd0, bus.lsb_done}, {31'd0, (j == 5)});
    end
    bus.lsb_req = 1'b0;
    next_cycle();
    chk("io write count", io_wr_cnt, 1);
    chk("io write byte", {24'd0, io_last}, 32'h41);

    // Flush during the second byte of a load.
    bus.lsb_we = 1'b0; bus.lsb_size = 2'd2; bus.lsb_addr = 32'h100; bus.lsb_req = 1'b1;
    next_cycle();
    @(posedge clk_in);
    #1;
    control_hazard = 1'b1;
    #1;
    chk("flush second byte addr", bus.mem_a, 32'h101);
    for (int j = 3; j <= 8; j++) begin
      @(posedge clk_in);
      #1;
      control_hazard = 1'b0;
      bus.lsb_req = 1'b0;
      #1;
      if (j == 3) chk("flush idle mem_a", bus.mem_a, 32'd0);
      chk($sformatf("flush no done j=%0d", j), {31'd0, bus.lsb_done}, 32'd0);
    end
    chk("flush rdata held", bus.lsb_rdata, 32'h90AB_CDEF);
    next_cycle();

    // A store ignores control_hazard and completes all four bytes.
    control_hazard = 1'b1;
    do_lsb(1'b1, 2'd2, 32'h120, 32'h1122_3344, 0, -1, lat, rd);
    control_hazard = 1'b0;
    chk("hazard store latency", lat, 5);
    next_cycle();
    chk("hazard store bytes", {ram[10'h123], ram[10'h122], ram[10'h121], ram[10'h120]}, 32'h1122_3344);

    // Reset for one cycle after the first byte of a store.
    bus.lsb_we = 1'b1; bus.lsb_size = 2'd2; bus.lsb_addr = 32'h130;
    bus.lsb_wdata = 32'hAABB_CCDD; bus.lsb_req = 1'b1;
    next_cycle();
    #1;
    chk("pre-reset write", {31'd0, bus.mem_wr}, 32'd1);
    chk("pre-reset addr", bus.mem_a, 32'h130);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    bus.lsb_req = 1'b0;
    #1;
    chk("mid reset mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("mid reset mem_a", bus.mem_a, 32'd0);
    chk("mid reset mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    for (int j = 3; j <= 7; j++) begin
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      #1;
      chk($sformatf("post reset done j=%0d", j), {31'd0, bus.lsb_done}, 32'd0);
      chk($sformatf("post reset mem_wr j=%0d", j), {31'd0, bus.mem_wr}, 32'd0);
      if (j == 3) chk("post reset rdata", bus.lsb_rdata, 32'd0);
    end
    chk("reset store byte0", {24'd0, ram[10'h130]}, 32'hDD);
    chk("reset store byte1", {24'd0, ram[10'h131]}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory arbiter between the instruction fetch unit (IF) and the load/store buffer (LSB), directly upstream of IF. It owns the single-port RAM/IO bus (one byte per cycle, 1-cycle read latency). It grants IF one byte address per cycle and sequences 1/2/4-byte LSB loads and stores. It also honours the IO write back-pressure and the ROB control-hazard flush.

## Interface
Parameters:
- IO_BASE, 32'h30000, addresses at or above this are IO; writes to them are gated by io_buffer_full.

Ports:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high, rst_in.
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- control_hazard  in  1  ROB flush.
- io_buffer_full  in  1  IO sink cannot take a byte.
- mem_din  in  8  RAM read byte, valid one cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write this cycle.
- if_req  in  1  IF wants a byte (IF access_control).
- if_addr  in  32  byte address IF wants this cycle.
- if_grant  out  1  if_addr issued to RAM this cycle (IF access_valid).
- lsb_req  in  1  LSB request, held until lsb_done.
- lsb_we  in  1  1 = store.
- lsb_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal.
- lsb_addr  in  32  base address.
- lsb_wdata  in  32  store data; low bytes used.
- lsb_done  out  1  one-cycle completion pulse, registered.
- lsb_rdata  out  32  zero-extended load result, valid with lsb_done, held until the next done.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_FIN, LS_WR.
- mem_a, mem_wr, mem_dout and if_grant are combinational from state and inputs. lsb_done and lsb_rdata are registered.
- IDLE: no bus access. Next state is LS_WR or LS_RD if lsb_req is high and lsb_done is low; otherwise IF_RD if if_req; otherwise IDLE. The LSB has priority.
- IF_RD: if if_req is high, then mem_a = if_addr, if_grant = 1, and the granted-byte count increments (mod 4).
  - When the count reaches 4 (a word boundary), re-arbitrate in the same cycle: LSB first, else stay in IF_RD if if_req, else IDLE. No bubble.
  - If if_req is low, go to IDLE and clear the count. IF tracks its own offset.
- LS_RD: issue lsb_addr+k, k = 0..n-1, one byte per cycle. Byte k from mem_din is stored into lsb_rdata[8k+7:8k] (little-endian). After the last issue, go to LS_FIN.
- LS_FIN: capture the last byte, pulse lsb_done, go to IDLE.
- LS_WR: mem_wr = 1, mem_a = lsb_addr+k, mem_dout = lsb_wdata[8k+7:8k].
  - If mem_a >= IO_BASE and io_buffer_full is high, drive mem_wr = 0 and hold k.
  - After the last byte, pulse lsb_done and go to IDLE.
- Address arithmetic is 32-bit with wrap; offset k is 2 bits.
- control_hazard:
  - In IF_RD or LS_RD/LS_FIN: force if_grant = 0 and mem_wr = 0 that cycle, go to IDLE next cycle, and produce no lsb_done for the aborted load.
  - In LS_WR: ignored. The committed store completes.
- rdy_in low: state, k and count are frozen; mem_wr = 0 and if_grant = 0. A read byte issued in the preceding active cycle is still captured.
- lsb_size = 3 is treated as 4 bytes.
- Reset: state IDLE; k and count 0; mem_a 0, mem_dout 0, mem_wr 0, if_grant 0, lsb_done 0, lsb_rdata 0.

## Timing
- IF: the first grant comes one cycle after IDLE sees if_req. After that, one byte per cycle continuously while if_req is held and no LSB request arrives. Data appears on mem_din one cycle after each grant.
- Load of n bytes accepted in IDLE at cycle a: issues at a+1..a+n, LS_FIN at a+n+1, lsb_done high at a+n+2.
- Store of n bytes accepted at a: writes at a+1..a+n (plus one cycle per IO stall), lsb_done at a+n+1.
- LSB handshake: the LSB must drop or replace lsb_req in the cycle after lsb_done. IDLE ignores lsb_req while lsb_done is high.

## Structure
- Shared package: state enum, size encodings, IO_BASE.
- Single module; no sub-module required.

## Test plan
- IF streaming: if_req held, if_addr 0,1,2,…: if_grant high every cycle from reset+2, mem_a follows if_addr, mem_wr stays 0.
- Word load: RAM[0x100..0x103] = 78 56 34 12, LSB load size 2 at 0x100 accepted at cycle a: lsb_done at a+6 with lsb_rdata = 0x12345678.
- Priority at boundary: IF streaming and lsb_req raised mid-word: IF receives its remaining grants up to the 4th, then LS_RD starts with no idle cycle; IF resumes after lsb_done.
- IO store stall: sb 0x41 to 0x30000 with io_buffer_full high for 3 cycles: mem_wr low for 3 cycles, then one write of 0x41, lsb_done the next cycle.
- Flush: control_hazard during the 2nd byte of a load: no lsb_done, IDLE next cycle. control_hazard during a store: all 4 bytes written and lsb_done asserted.
- Reset mid-store: rst_in high for one cycle after byte 1: mem_wr 0, all outputs at reset values, no lsb_done.
